// File: rtl/fpm_seq.sv
// Batch sequencer for the fpm multiplier: fetches N_OPS operand pairs, handshakes
// each through the multiplier and keeps the products in a judge-readable result RAM.
module fpm_seq #(
   parameter int unsigned N_OPS  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] op_addr,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   output logic [31:0]       mul_a,
   output logic [31:0]       mul_b,
   output logic              mul_start,
   input  logic [31:0]       mul_result,
   input  logic              mul_done,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] ram_addr_juiz,
   output logic [31:0]       ram_out_juiz
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OPS - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic [31:0]       mul_a_q;
   logic [31:0]       mul_b_q;
   logic              mul_start_q;
   logic              busy_q;
   logic              done_q;
   logic [31:0]       result_q [N_OPS];

   assign idx_d = idx_q + ADDR_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int unsigned i = 0; i < N_OPS; i++) begin
            result_q[i] <= '0;
         end
      end else begin
         mul_start_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: state_q <= S_LOAD;
            // op_a/op_b are the synchronous read of the address presented in FETCH
            S_LOAD: begin
               mul_a_q     <= op_a;
               mul_b_q     <= op_b;
               mul_start_q <= 1'b1;
               state_q     <= S_START;
            end
            S_START: state_q <= S_WAIT;
            S_WAIT: begin
               if (mul_done) begin
                  result_q[idx_q] <= mul_result;
                  state_q         <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (idx_q == LAST_IDX) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_d;
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // idx only changes on leaving WRITE, so it is already the FETCH address
   assign op_addr      = idx_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign mul_start    = mul_start_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign ram_out_juiz = result_q[ram_addr_juiz];

endmodule

// File: tb/tb_fpm_seq.sv
// Bench for fpm_seq: operand memory and multiplier models with programmable latency,
// results and timing compared against values derived from the batch rules.
module tb_fpm_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op_addr;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_start;
   logic [31:0] mul_result;
   logic        mul_done;
   logic        busy;
   logic        done;
   logic [1:0]  ram_addr_juiz;
   logic [31:0] ram_out_juiz;

   fpm_seq #(.N_OPS(4), .ADDR_W(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .op_addr      (op_addr),
      .op_a         (op_a),
      .op_b         (op_b),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_start    (mul_start),
      .mul_result   (mul_result),
      .mul_done     (mul_done),
      .busy         (busy),
      .done         (done),
      .ram_addr_juiz(ram_addr_juiz),
      .ram_out_juiz (ram_out_juiz)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] spec_a   [4] = '{32'h3FC00000, 32'h40400000, 32'hBF800000, 32'h00000000};
   logic [31:0] spec_b   [4] = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h42280000};
   logic [31:0] spec_exp [4] = '{32'h40400000, 32'h41100000, 32'hC0A00000, 32'h00000000};

   logic [31:0] mem_a [4];
   logic [31:0] mem_b [4];
   logic [31:0] ref_ram [4];
   int          w_tab [4];
   int          pulse_idx = 0;
   int          pulses = 0;
   int          wide_err = 0;
   int          hi_run = 0;
   int          stab_err = 0;
   bit          spurious = 1'b0;
   bit          mdl_abort = 1'b0;
   logic [31:0] old3;

   // Multiplier stand-in: IEEE products for the known pairs, a scrambled integer product otherwise
   function automatic logic [31:0] mulf(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3FC00000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'h40400000}: return 32'h41100000;
         {32'hBF800000, 32'h40A00000}: return 32'hC0A00000;
         {32'h00000000, 32'h42280000}: return 32'h00000000;
         default:                      return (a * b) ^ 32'h13579BDF;
      endcase
   endfunction

   // Synchronous-read operand memory
   always @(posedge clock) begin
      op_a <= mem_a[op_addr];
      op_b <= mem_b[op_addr];
   end

   always @(negedge clock) begin
      if (mul_start === 1'b1) begin
         pulses++;
         hi_run++;
         if (hi_run > 1) wide_err++;
      end else begin
         hi_run = 0;
      end
   end

   logic [31:0] m_a, m_b, m_p;
   int          m_k;
   always begin
      @(negedge clock);
      if (mul_start === 1'b1) begin
         m_k = pulse_idx % 4;
         pulse_idx++;
         m_a = mul_a;
         m_b = mul_b;
         m_p = mulf(m_a, m_b);
         repeat (w_tab[m_k]) begin
            @(negedge clock);
            if (!mdl_abort && (mul_a !== m_a || mul_b !== m_b)) stab_err++;
         end
         mul_done   = 1'b1;
         mul_result = m_p;
         @(posedge clock);
         if (!mdl_abort) ref_ram[m_k] = m_p;
         @(negedge clock);
         if (spurious) begin
            mul_result = 32'hDEADBEEF;
            @(negedge clock);
            @(negedge clock);
         end
         mul_done   = 1'b0;
         mul_result = '0;
      end
   end

   task automatic load_spec;
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = spec_a[i];
         mem_b[i] = spec_b[i];
      end
   endtask

   task automatic load_random;
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = $urandom;
         mem_b[i] = $urandom;
      end
   endtask

   task automatic kick(input int inject_at, output int lat);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 600) begin
         @(posedge clock);
         #1;
         lat++;
         start = (inject_at != 0 && lat == inject_at);
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
      n_cmp++; if (op_addr !== 2'd0)   begin n_err++; $display("FAIL reset_op_addr: got %0d want 0", op_addr); end
      n_cmp++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin
         n_err++; $display("FAIL reset_mul_ops: got %h/%h want 0/0", mul_a, mul_b);
      end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== 32'h0) begin
            n_err++; $display("FAIL reset_ram[%0d]: got %h want 00000000", i, ram_out_juiz);
         end
      end
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic;
      int lat;
      load_spec();
      w_tab = '{1, 1, 1, 1};
      pulse_idx = 0; pulses = 0; wide_err = 0; stab_err = 0;
      kick(0, lat);
      n_cmp++; if (lat !== 21) begin n_err++; $display("FAIL basic_latency: got %0d want 21", lat); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done: got %b want 0", busy); end
      n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL basic_pulses: got %0d want 4", pulses); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== spec_exp[i]) begin
            n_err++; $display("FAIL basic_result[%0d]: got %h want %h", i, ram_out_juiz, spec_exp[i]);
         end
      end
   endtask

   task automatic test_var_latency;
      int lat;
      load_spec();
      w_tab = '{1, 5, 3, 8};
      pulse_idx = 0; pulses = 0; wide_err = 0; stab_err = 0;
      kick(0, lat);
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL varlat_latency: got %0d want 34", lat); end
      n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL varlat_pulses: got %0d want 4", pulses); end
      n_cmp++; if (wide_err !== 0) begin n_err++; $display("FAIL varlat_pulse_width: got %0d wide want 0", wide_err); end
      n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL varlat_operand_stable: got %0d changes want 0", stab_err); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== spec_exp[i]) begin
            n_err++; $display("FAIL varlat_result[%0d]: got %h want %h", i, ram_out_juiz, spec_exp[i]);
         end
      end
   endtask

   task automatic test_spurious;
      int lat;
      load_spec();
      w_tab = '{3, 3, 3, 3};
      spurious = 1'b1;
      pulse_idx = 0; pulses = 0;
      kick(4, lat);
      repeat (4) @(posedge clock);
      #1;
      spurious = 1'b0;
      n_cmp++; if (lat !== 29) begin n_err++; $display("FAIL spurious_latency: got %0d want 29", lat); end
      n_cmp++; if (pulses !== 4) begin n_err++; $display("FAIL spurious_pulses: got %0d want 4", pulses); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL spurious_done_held: got %b want 1", done); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== spec_exp[i]) begin
            n_err++; $display("FAIL spurious_result[%0d]: got %h want %h", i, ram_out_juiz, spec_exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      int busy_seen;
      load_spec();
      w_tab = '{1, 1, 8, 1};
      pulse_idx = 0; pulses = 0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat = 1;
      // pair 2 waits in cycles 14..21
      while (lat < 16) begin
         @(posedge clock);
         #1;
         lat++;
      end
      n_cmp++; if (busy !== 1'b1 || pulses !== 3) begin
         n_err++; $display("FAIL midreset_pre: got busy=%b pulses=%0d want busy=1 pulses=3", busy, pulses);
      end
      reset = 1'b1;
      mdl_abort = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL midreset_done: got %b want 0", done); end
      n_cmp++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL midreset_mul_start: got %b want 0", mul_start); end
      n_cmp++; if (op_addr !== 2'd0)   begin n_err++; $display("FAIL midreset_idx: got %0d want 0", op_addr); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== 32'h0) begin
            n_err++; $display("FAIL midreset_ram[%0d]: got %h want 00000000", i, ram_out_juiz);
         end
      end
      reset = 1'b0;
      busy_seen = 0;
      repeat (12) begin
         @(posedge clock);
         #1;
         if (busy !== 1'b0) busy_seen++;
      end
      n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL midreset_stays_idle: got %0d busy cycles want 0", busy_seen); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== 32'h0) begin
            n_err++; $display("FAIL stale_done_ram[%0d]: got %h want 00000000", i, ram_out_juiz);
         end
      end
      mdl_abort = 1'b0;
      for (int i = 0; i < 4; i++) ref_ram[i] = '0;
      w_tab = '{1, 1, 1, 1};
      pulse_idx = 0; pulses = 0;
      kick(0, lat);
      n_cmp++; if (lat !== 21) begin n_err++; $display("FAIL after_reset_latency: got %0d want 21", lat); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== spec_exp[i]) begin
            n_err++; $display("FAIL after_reset_result[%0d]: got %h want %h", i, ram_out_juiz, spec_exp[i]);
         end
      end
   endtask

   task automatic test_random;
      int lat;
      int exp_lat;
      load_random();
      exp_lat = 1;
      for (int i = 0; i < 4; i++) begin
         w_tab[i] = $urandom_range(1, 6);
         exp_lat += 4 + w_tab[i];
      end
      pulse_idx = 0; pulses = 0; stab_err = 0;
      kick(0, lat);
      n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL random_latency: got %0d want %0d", lat, exp_lat); end
      n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL random_operand_stable: got %0d changes want 0", stab_err); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== mulf(mem_a[i], mem_b[i])) begin
            n_err++; $display("FAIL random_result[%0d]: got %h want %h", i, ram_out_juiz, mulf(mem_a[i], mem_b[i]));
         end
      end
      old3 = mulf(mem_a[3], mem_b[3]);
   endtask

   task automatic test_rerun;
      int lat;
      int exp_lat;
      int w3_bad;
      load_random();
      while (mulf(mem_a[3], mem_b[3]) === old3) mem_b[3] = $urandom;
      exp_lat = 1;
      for (int i = 0; i < 4; i++) begin
         w_tab[i] = $urandom_range(1, 4);
         exp_lat += 4 + w_tab[i];
      end
      pulse_idx = 0; pulses = 0;
      ram_addr_juiz = 2'd3;
      #1;
      n_cmp++; if (ram_out_juiz !== old3) begin n_err++; $display("FAIL rerun_word3_before: got %h want %h", ram_out_juiz, old3); end
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat = 1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
         n_err++; $display("FAIL rerun_done_drop: got done=%b busy=%b want done=0 busy=1", done, busy);
      end
      w3_bad = 0;
      while (done !== 1'b1 && lat < 600) begin
         if (ram_out_juiz !== ref_ram[3]) w3_bad++;
         @(posedge clock);
         #1;
         lat++;
      end
      n_cmp++; if (w3_bad !== 0) begin n_err++; $display("FAIL rerun_word3_timing: got %0d wrong cycles want 0", w3_bad); end
      n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL rerun_latency: got %0d want %0d", lat, exp_lat); end
      for (int i = 0; i < 4; i++) begin
         ram_addr_juiz = 2'(i);
         #1;
         n_cmp++; if (ram_out_juiz !== mulf(mem_a[i], mem_b[i])) begin
            n_err++; $display("FAIL rerun_result[%0d]: got %h want %h", i, ram_out_juiz, mulf(mem_a[i], mem_b[i]));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      mul_done      = 1'b0;
      mul_result    = '0;
      ram_addr_juiz = '0;
      w_tab         = '{1, 1, 1, 1};
      for (int i = 0; i < 4; i++) begin
         mem_a[i]   = '0;
         mem_b[i]   = '0;
         ref_ram[i] = '0;
      end
      test_reset();
      test_basic();
      test_var_latency();
      test_spurious();
      test_reset_mid();
      test_random();
      test_rerun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fpm_seq.md
# fpm_seq

Sequencer for the floating-point multiplier datapath (`fpm`). On `start`, it walks a 4-entry operand memory and feeds each operand pair to the multiplier. It handshakes on the multiplier's `start`/`done`, stores each 32-bit product in an internal result RAM, and then raises `done`. The result RAM has a judge read port (`ram_addr_juiz`/`ram_out_juiz`) so benches and the judge can read products after `done`.

## Interface
- `N_OPS`, 4: number of operand pairs and result words; must equal 2^`ADDR_W`.
- `ADDR_W`, 2: width of operand and result addresses.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `start` in 1: request to run a batch; sampled only in IDLE and DONE.
- `op_addr` out `ADDR_W`: address to the operand memory; registered.
- `op_a` in 32: operand A; valid the cycle after `op_addr` is presented (synchronous read).
- `op_b` in 32: operand B; same timing as `op_a`.
- `mul_a` out 32: registered operand A to the multiplier.
- `mul_b` out 32: registered operand B to the multiplier.
- `mul_start` out 1: one-cycle pulse; operands are stable from this pulse until `mul_done`.
- `mul_result` in 32: product; valid while `mul_done`=1.
- `mul_done` in 1: multiplier completion; may be a level or a pulse.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: batch complete; held until the next accepted `start` or `reset`.
- `ram_addr_juiz` in `ADDR_W`: judge read address.
- `ram_out_juiz` out 32: combinational read of `result[ram_addr_juiz]`; independent of the FSM state.

## Operation
- Registers:
  - FSM state.
  - index `idx` (`ADDR_W` bits).
  - `mul_a`, `mul_b`.
  - result RAM `result[0..N_OPS-1]`, 32 bits each.
- Reset values:
  - state IDLE, `idx` 0.
  - `op_addr` 0, `mul_a`/`mul_b` 0.
  - `mul_start`, `busy`, `done` 0.
  - all `result` words 0.
- FSM states and transitions:
  - IDLE: if `start`, set `idx`=0 and go to FETCH. Otherwise stay.
  - FETCH: drive `op_addr`=`idx`; go to LOAD.
  - LOAD: latch `mul_a`<=`op_a`, `mul_b`<=`op_b`; go to START.
  - START: `mul_start`=1 for exactly this cycle; go to WAIT.
  - WAIT: hold `mul_a`/`mul_b`. If `mul_done`, write `result[idx]`<=`mul_result` and go to WRITE. Otherwise stay; there is no timeout.
  - WRITE: if `idx`=N_OPS-1, go to DONE. Otherwise `idx`<=`idx`+1 and go to FETCH.
  - DONE: `done`=1. If `start`, clear `done`, set `idx`=0 and go to FETCH (rerun). Otherwise stay.
- The result RAM is written only from WAIT, at most once per operand pair.
- The index never wraps mid-batch. The last pair exits to DONE rather than incrementing past N_OPS-1.
- The block performs no arithmetic on data. Products are stored bit-exact, with no rounding or flag handling.

## Timing
- Edge 0 samples `start` in IDLE.
- Per operand pair: FETCH, LOAD, START, WAIT, WRITE = 4 + W cycles.
  - W ≥ 1 is the number of WAIT cycles.
  - If `mul_done` is high in the cycle right after the `mul_start` pulse, then W=1.
- Batch latency from sampled `start` to first cycle with `done`=1: N_OPS·(4+W)+1 cycles. With N_OPS=4 and W=1 this is 21 cycles.
- `mul_done` seen outside WAIT is ignored, so a stale done cannot write a result.
- `start` while `busy` is ignored; it is neither queued nor restarting.
- `start` and `reset` in the same cycle: reset wins.
- `reset` mid-batch:
  - next state IDLE, `idx` 0, `mul_start` 0.
  - all result words cleared; partial results are discarded.
- A rerun from DONE overwrites results in order. Until each word is rewritten, `ram_out_juiz` returns the previous batch's value.
- A judge read in the same cycle as a write to that word returns the old value; the new value appears after the edge.

## Test plan
- Basic batch, multiplier model latency W=1, `start` held for one cycle:
  - operands: 3FC00000×40000000, 40400000×40400000, BF800000×40A00000, 00000000×42280000.
  - required: `done` after 21 cycles.
  - required judge reads: 40400000, 41100000, C0A00000, 00000000.
- Variable latency W=1,5,3,8 on successive pairs:
  - required: exactly one `mul_start` pulse per pair.
  - required: `mul_a`/`mul_b` stable from each pulse to its `mul_done`.
  - required: same results as the basic batch.
- Spurious `mul_done` pulses in FETCH and LOAD, and `start` pulsed in WAIT:
  - required: no extra writes, no restart, results unchanged.
- Reset asserted in WAIT of pair 2:
  - required: next cycle IDLE, `busy`=0, `done`=0, all judge reads 00000000.
  - then `start`: full correct batch.
- Rerun from DONE with new operand memory contents:
  - required: `done` drops the cycle after `start` is sampled.
  - required: word 3 keeps its old value until pair 3's WAIT completes.
  - required: final results are the new products.
